// File: rtl/xx6812_pkg.sv
// ============================================================================
//  Module      : xx6812_pkg
//  Description : Shared constants for the XX6812 encoder: timing defaults,
//                state encodings and word geometry.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package xx6812_pkg;

`include "xx6812_params.vh"

    // Word geometry: 24-bit GRB word, sent MSB first
    localparam int WORD_BITS = 24;
    localparam int BIT_CNT_W = 5;
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = 5'd23;

endpackage

`default_nettype wire

// File: rtl/rising_edge_detector.sv
// ============================================================================
//  Module      : rising_edge_detector
//  Description : One-cycle pulse on a 0->1 transition of din. The history
//                register resets to 1 so a level already high when reset is
//                released never looks like an edge.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rising_edge_detector (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic pulse
);

    logic din_prev;

    // Remember the previous sampled level of din
    always_ff @(posedge clk) begin
        if (rst) begin
            din_prev <= 1'b1;
        end else begin
            din_prev <= din;
        end
    end

    assign pulse = din & ~din_prev;

endmodule

`default_nettype wire

// File: rtl/xx6812_params.vh
// ============================================================================
//  File        : xx6812_params.vh
//  Description : Default bit timings and FSM state encodings for the
//                XX6812 serial LED encoder. Shared by package and design.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef XX6812_PARAMS_VH
`define XX6812_PARAMS_VH

// Timing defaults, in clock_12mhz cycles
localparam int XX_T_BIT_DEFAULT   = 15;   // 1.25 us per data bit
localparam int XX_T0H_DEFAULT     = 4;    // 0.33 us high for a '0'
localparam int XX_T1H_DEFAULT     = 9;    // 0.75 us high for a '1'
localparam int XX_T_LATCH_DEFAULT = 640;  // 53.3 us low latch gap

// FSM state encodings
localparam logic [1:0] ST_IDLE     = 2'd0;
localparam logic [1:0] ST_BIT_HIGH = 2'd1;
localparam logic [1:0] ST_BIT_LOW  = 2'd2;
localparam logic [1:0] ST_LATCH    = 2'd3;

`endif

`default_nettype wire

// File: rtl/xx6812_encoder.sv
// ============================================================================
//  Module      : xx6812_encoder
//  Description : Serialises a 24-bit GRB word onto a single-wire LED line.
//                Each bit is a high pulse (T1H or T0H) followed by a low
//                tail filling T_BIT cycles. A latch request queues a low
//                gap of T_LATCH cycles that runs once the encoder is idle.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module xx6812_encoder
    import xx6812_pkg::*;
#(
    parameter int T_BIT   = XX_T_BIT_DEFAULT,
    parameter int T0H     = XX_T0H_DEFAULT,
    parameter int T1H     = XX_T1H_DEFAULT,
    parameter int T_LATCH = XX_T_LATCH_DEFAULT
) (
    input  logic        clock_12mhz,
    input  logic        reset,
    input  logic        encoder_start,
    input  logic [23:0] pixel_data,
    input  logic        latch_request,
    output logic        dout,
    output logic        busy,
    output logic        word_done,
    output logic        latch_done
);

    // Phase counter must hold the longest interval timed by the FSM
    localparam int PHASE_MAX = (T_BIT > T_LATCH) ? T_BIT : T_LATCH;
    localparam int PHASE_W   = $clog2(PHASE_MAX + 1);

    localparam logic [PHASE_W-1:0] C_ONE        = PHASE_W'(1);
    localparam logic [PHASE_W-1:0] C_T_BIT      = PHASE_W'(T_BIT);
    localparam logic [PHASE_W-1:0] C_T0H        = PHASE_W'(T0H);
    localparam logic [PHASE_W-1:0] C_T1H        = PHASE_W'(T1H);
    localparam logic [PHASE_W-1:0] C_LATCH_LAST = PHASE_W'(T_LATCH - 1);

    logic [1:0]           state;
    logic [PHASE_W-1:0]   phase;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic [WORD_BITS-1:0] shift_reg;
    logic                 latch_pending;
    logic                 start_edge;

    logic [PHASE_W-1:0]   high_len;
    logic [PHASE_W-1:0]   high_last;
    logic [PHASE_W-1:0]   low_last;

    rising_edge_detector u_start_edge (
        .clk   (clock_12mhz),
        .rst   (reset),
        .din   (encoder_start),
        .pulse (start_edge)
    );

    // The bit currently on the wire always sits in the MSB of the shift register
    assign high_len  = shift_reg[WORD_BITS-1] ? C_T1H : C_T0H;
    assign high_last = high_len - C_ONE;
    assign low_last  = C_T_BIT - high_len - C_ONE;

    // Bit-timing FSM; all outputs are registered alongside the state
    always_ff @(posedge clock_12mhz) begin
        if (reset) begin
            state         <= ST_IDLE;
            phase         <= '0;
            bit_cnt       <= '0;
            shift_reg     <= '0;
            latch_pending <= 1'b0;
            dout          <= 1'b0;
            busy          <= 1'b0;
            word_done     <= 1'b0;
            latch_done    <= 1'b0;
        end else begin
            word_done  <= 1'b0;
            latch_done <= 1'b0;

            case (state)
                ST_IDLE: begin
                    // A start edge has priority; a pending latch waits for the next idle cycle
                    if (start_edge) begin
                        shift_reg <= pixel_data;
                        bit_cnt   <= '0;
                        phase     <= '0;
                        state     <= ST_BIT_HIGH;
                        dout      <= 1'b1;
                        busy      <= 1'b1;
                    end else if (latch_pending) begin
                        latch_pending <= 1'b0;
                        phase         <= '0;
                        state         <= ST_LATCH;
                        dout          <= 1'b0;
                        busy          <= 1'b1;
                    end
                end

                ST_BIT_HIGH: begin
                    if (phase == high_last) begin
                        phase <= '0;
                        state <= ST_BIT_LOW;
                        dout  <= 1'b0;
                    end else begin
                        phase <= phase + C_ONE;
                    end
                end

                ST_BIT_LOW: begin
                    if (phase == low_last) begin
                        phase <= '0;
                        if (bit_cnt == LAST_BIT) begin
                            state     <= ST_IDLE;
                            busy      <= 1'b0;
                            word_done <= 1'b1;
                        end else begin
                            shift_reg <= {shift_reg[WORD_BITS-2:0], 1'b0};
                            bit_cnt   <= bit_cnt + 5'd1;
                            state     <= ST_BIT_HIGH;
                            dout      <= 1'b1;
                        end
                    end else begin
                        phase <= phase + C_ONE;
                    end
                end

                ST_LATCH: begin
                    if (phase == C_LATCH_LAST) begin
                        phase      <= '0;
                        state      <= ST_IDLE;
                        busy       <= 1'b0;
                        latch_done <= 1'b1;
                    end else begin
                        phase <= phase + C_ONE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    dout  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase

            // A request in any state is remembered, even on the cycle a latch starts
            if (latch_request) begin
                latch_pending <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire
